// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: 2-FF sync, debounce filter, press/release/long pulses per key.
// Optional auto-repeat of key_press after key_long is built when KEY_AUTOREPEAT_EN is defined.

module key_debounce_lane #(
  parameter int DB_CNT     = 4,
  parameter int LONG_CNT   = 20,
  parameter int RPT_CNT    = 5,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel,
  output logic lng
);
  localparam int   DW   = $clog2(DB_CNT + 1);
  localparam int   HW   = $clog2(LONG_CNT + 1);
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic          s;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic          flip;
  logic          long_hit;
  logic          rpt_hit;

  // Sync flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= {2{IDLE}};
    else       sync <= {sync[0], raw};
  end

  assign s        = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
  assign flip     = (s != state) && (dcnt == DW'(DB_CNT - 1));
  // A release in the same cycle wins over the long-press pulse.
  assign long_hit = state && !flip && (hcnt == HW'(LONG_CNT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt  <= '0;
      hcnt  <= '0;
      state <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      lng   <= 1'b0;
    end else begin
      if (s == state || flip) dcnt <= '0;
      else                    dcnt <= dcnt + 1'b1;
      if (flip) state <= s;

      // hcnt stops at LONG_CNT so key_long fires once per press.
      if (!state || flip)              hcnt <= '0;
      else if (hcnt != HW'(LONG_CNT))  hcnt <= hcnt + 1'b1;

      press <= (flip & s) | rpt_hit;
      rel   <= flip & ~s;
      lng   <= long_hit;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(RPT_CNT + 1);
  logic          rpt_on;
  logic [RW-1:0] rcnt;

  assign rpt_hit = rpt_on && state && !flip && (rcnt == RW'(RPT_CNT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rpt_on <= 1'b0;
      rcnt   <= '0;
    end else if (!state || flip) begin
      rpt_on <= 1'b0;
      rcnt   <= '0;
    end else if (long_hit) begin
      rpt_on <= 1'b1;
      rcnt   <= '0;
    end else if (rpt_on) begin
      rcnt   <= rpt_hit ? '0 : rcnt + 1'b1;
    end
  end
`else
  // Repeat disabled: constant-false term keeps RPT_CNT referenced.
  assign rpt_hit = (RPT_CNT < 0);
`endif

endmodule

module key_debounce_multi #(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_FREQ    = 125_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);
  localparam longint unsigned DB_L   = 64'(CLK_FREQ) * 64'(DEBOUNCE_MS) / 64'd1000;
  localparam longint unsigned LONG_L = 64'(CLK_FREQ) * 64'(LONG_MS)     / 64'd1000;
  localparam longint unsigned RPT_L  = 64'(CLK_FREQ) * 64'(REPEAT_MS)   / 64'd1000;
  localparam int DB_CNT   = int'(DB_L);
  localparam int LONG_CNT = int'(LONG_L);
  localparam int RPT_CNT  = int'(RPT_L);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_debounce_lane #(
      .DB_CNT    (DB_CNT),
      .LONG_CNT  (LONG_CNT),
      .RPT_CNT   (RPT_CNT),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .raw  (key_raw[g]),
      .state(key_state[g]),
      .press(key_press[g]),
      .rel  (key_release[g]),
      .lng  (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: timestamp-based reference model feeding a scoreboard queue,
// directed timing checks, and randomized bouncing key traffic.

module tb_key_debounce_multi;
  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int RPT  = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NK-1:0] key_raw = '1;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .NUM_KEYS(NK), .CLK_FREQ(1000), .DEBOUNCE_MS(4), .LONG_MS(20),
    .REPEAT_MS(5), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rstn(rstn), .key_raw(key_raw),
    .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  typedef struct packed {
    logic [NK-1:0] st, pr, rl, lg;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a level is accepted once the synchronised key (pin seen two
  // edges earlier) has disagreed with the accepted level for DB consecutive edges.
  // Long/repeat pulses are derived from the time elapsed since the accepted press.
  logic [NK-1:0] m_d1 = '0, m_d2 = '0, m_st = '0;
  int            m_run [NK];
  int            m_tp  [NK];
  int            m_n = 0;

  always @(posedge clk) begin
    obs_t e;
    logic s, flip;
    int   age;
    e = '0;
    if (!rstn) begin
      m_d1 = '0; m_d2 = '0; m_st = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_tp[k] = 0; end
    end else begin
      for (int k = 0; k < NK; k++) begin
        s    = m_d2[k];
        flip = 1'b0;
        if (s != m_st[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) flip = 1'b1;
        end else m_run[k] = 0;
        if (m_st[k] && !flip) begin
          age = m_n - m_tp[k];
          if (age == LONG) e.lg[k] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          if (age > LONG && ((age - LONG) % RPT) == 0) e.pr[k] = 1'b1;
`endif
        end
        if (flip) begin
          m_st[k]  = s;
          m_run[k] = 0;
          m_tp[k]  = m_n;
          if (s) e.pr[k] = 1'b1;
          else   e.rl[k] = 1'b1;
        end
      end
      m_d2 = m_d1;
      m_d1 = ~key_raw;
      m_n++;
    end
    e.st = m_st;
    exp_q.push_back(e);
  end

  // Monitor: the DUT presents a full output vector every cycle.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {key_state, key_press, key_release, key_long};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t got st=%b pr=%b rl=%b lg=%b want st=%b pr=%b rl=%b lg=%b",
                 $time, a.st, a.pr, a.rl, a.lg, e.st, e.pr, e.rl, e.lg);
      end
    end
  end

  task automatic chk(input string nm, input logic [NK-1:0] act, input logic [NK-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rstn = 1'b0;
    #1 chk("async_reset_outputs", key_state | key_press | key_release | key_long, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  int cnt [NK];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_state", key_state | key_press | key_release | key_long, '0);
    @(negedge clk);
    #1 rstn = 1'b1;
    cyc(5);

    // Clean press / release on key 0
    key_raw[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("press_latency", key_press, 4'b0001);
    chk("state_rise", key_state, 4'b0001);
    cyc(4);
    key_raw[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("release_latency", key_release, 4'b0001);
    chk("state_fall", key_state, 4'b0000);
    cyc(10);

    // Bounce on key 1
    key_raw[1] = 1'b0; cyc(3);
    key_raw[1] = 1'b1; cyc(1);
    key_raw[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("bounce_no_early", key_press | key_state, 4'b0000);
    @(posedge clk);
    #1 chk("bounce_press", key_press, 4'b0010);
    cyc(5);
    key_raw[1] = 1'b1; cyc(12);

    // Long hold on key 2
    key_raw[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("long_press", key_press, 4'b0100);
    repeat (19) @(posedge clk);
    #1 chk("long_not_early", key_long, 4'b0000);
    @(posedge clk);
    #1 chk("long_pulse", key_long, 4'b0100);
    cyc(110);
    key_raw[2] = 1'b1; cyc(12);

    // Simultaneous press on keys 0 and 3
    key_raw = 4'b0110;
    repeat (6) @(posedge clk);
    #1 chk("simul_press", key_press, 4'b1001);
    cyc(4);
    key_raw = 4'b1111; cyc(12);

    // Reset two cycles into debounce, key kept held
    key_raw[0] = 1'b0;
    repeat (4) @(posedge clk);
    do_reset();
    repeat (5) @(posedge clk);
    #1 chk("requal_no_early", key_press | key_state, 4'b0000);
    @(posedge clk);
    #1 chk("requal_press", key_press, 4'b0001);
    cyc(5);
    key_raw[0] = 1'b1; cyc(12);

    // Randomized bouncing traffic, mixed glitch and hold lengths
    for (int k = 0; k < NK; k++) cnt[k] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        cyc(1);
      end
      for (int k = 0; k < NK; k++) begin
        if (cnt[k] == 0) begin
          key_raw[k] = ~key_raw[k];
          cnt[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60);
        end else cnt[k]--;
      end
      cyc(1);
    end

    key_raw = '1;
    cyc(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
